jt12_stereo_acc: RTL

//  Upstream of the stereo limiting amplifier: sums per-channel FM/PCM samples, delivered

---
 rtl/jt12_stereo_acc.sv | 83 ++++++++
 1 files changed

// File: rtl/jt12_stereo_acc.sv
// Stereo frame accumulator: sums serial per-slot samples onto saturating left/right
// buses according to each slot's pan bits and emits one registered stereo sample per frame.
module jt12_stereo_acc #(
  parameter int CH_W  = 14,
  parameter int OUT_W = 20,
  parameter int NCH   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    ch_valid,
  input  logic signed [CH_W-1:0]  ch_data,
  input  logic                    ch_left,
  input  logic                    ch_right,
  input  logic                    ch_last,
  output logic signed [OUT_W-1:0] left_out,
  output logic signed [OUT_W-1:0] right_out,
  output logic                    out_valid,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(NCH + 1);
  localparam logic [CNT_W-1:0] NCH_C = CNT_W'(NCH);

  logic signed [OUT_W-1:0] acc_l, acc_r;
  logic        [CNT_W-1:0] cnt;
  logic signed [OUT_W:0]   ext, add_l, add_r, sum_l, sum_r;
  logic signed [OUT_W-1:0] nxt_l, nxt_r;
  logic                    accept, take;

  // The wide sum can only leave the OUT_W range by one bit; a sign mismatch
  // between the top two bits flags it and the top bit tells which rail to clamp to.
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [OUT_W:0] s);
    if (s[OUT_W] != s[OUT_W-1])
      sat = s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      sat = s[OUT_W-1:0];
  endfunction

  always_comb begin
    ext    = {{(OUT_W+1-CH_W){ch_data[CH_W-1]}}, ch_data};
    add_l  = ch_left  ? ext : '0;
    add_r  = ch_right ? ext : '0;
    sum_l  = {acc_l[OUT_W-1], acc_l} + add_l;
    sum_r  = {acc_r[OUT_W-1], acc_r} + add_r;
    nxt_l  = sat(sum_l);
    nxt_r  = sat(sum_r);
    accept = cen & ch_valid;
    take   = accept && (cnt < NCH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l     <= '0;
      acc_r     <= '0;
      cnt       <= '0;
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (!take)
          overrun <= 1'b1;
        if (ch_last) begin
          // An ignored closing slot still ends the frame with the sums held so far.
          left_out  <= take ? nxt_l : acc_l;
          right_out <= take ? nxt_r : acc_r;
          out_valid <= 1'b1;
          acc_l     <= '0;
          acc_r     <= '0;
          cnt       <= '0;
        end else if (take) begin
          acc_l <= nxt_l;
          acc_r <= nxt_r;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
